fcp_vout_ramp: RTL and testbench
================================

# fcp_vout_ramp

Output-voltage ramp controller that consumes the 2-bit `out_volt` request produced by the FCP core and turns it into a slew-limited reference code for the VBUS regulator DAC. It sits directly downstream of the FCP core. It also drives a discharge enable on down-steps, a fault fallback to 5 V, and a power-good flag that asserts only after the output has settled.

## Interface

Parameters:
- `CODE_W`, 11: DAC code width; 10 mV/LSB.
- `STEP_LSB`, 1: maximum code change per step.
- `STEP_CYCLES`, 100: clock cycles per step (≥1).
- `SETTLE_CYCLES`, 1000: settle time after a ramp completes (≥1).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `out_volt`  in  2  request from the FCP core: 00 = 5 V, 01 = 9 V, 10 = 12 V, 11 = reserved and treated as 5 V.
- `fault`  in  1  level; OVP/OCP from the analog front end.
- `vref_code`  out  CODE_W  DAC reference code.
- `ramp_busy`  out  1  high in RAMP_UP or RAMP_DN.
- `dischg_en`  out  1  VBUS bleeder enable.
- `vout_ok`  out  1  power good.

## Operation

Target decode, registered into `tgt` every cycle:
- 5 V → 500, 9 V → 900, 12 V → 1200.
- While `fault` = 1, `tgt` is forced to 500.

States:
- **SETTLE**
  - Settle counter runs; `vout_ok` = 0.
  - Counter expiry with `tgt` == `vref_code` → IDLE.
  - `tgt` ≠ `vref_code` → RAMP_UP or RAMP_DN immediately; the counter is abandoned.
- **IDLE**
  - `vout_ok` = 1.
  - `tgt` > `vref_code` → RAMP_UP.
  - `tgt` < `vref_code` → RAMP_DN.
- **RAMP_UP / RAMP_DN**
  - The step timer reloads to STEP_CYCLES−1 on entry.
  - On timer == 0, `vref_code` moves toward `tgt` by min(STEP_LSB, |tgt − vref_code|), which never overshoots, and the timer reloads.
  - `dischg_en` = 1 in RAMP_DN only.
  - Code reaches `tgt` → SETTLE.
  - If `tgt` reverses direction mid-ramp, switch to the other RAMP state on the next edge from the current code, with the timer reloaded. No code jump.
- **FAULT**
  - Entered from any state on `fault` = 1; takes priority over every transition.
  - `vref_code` is forced to 500 on the entry edge.
  - `dischg_en` = 1, `vout_ok` = 0, `ramp_busy` = 0.
  - Exit when `fault` = 0 → SETTLE with the counter reloaded.

Rules:
- The code is unsigned CODE_W bits. Differences are computed at CODE_W+1 bits, so no wrap-around is possible.
- `out_volt` changes during SETTLE or a ramp are honoured on the next compare; there is no request queue and only the latest target matters.
- Reset mid-operation abandons everything and returns to the reset values below.

## Timing

Reset values:
- state = SETTLE, settle counter = SETTLE_CYCLES−1.
- `vref_code` = 500, `ramp_busy` = 0, `dischg_en` = 0, `vout_ok` = 0.

Latency:
- `out_volt` change sampled at edge N → `tgt` valid after edge N.
- State change and `ramp_busy` high after edge N+1; `vout_ok` drops in the same cycle.
- First code step after edge N+1+STEP_CYCLES.
- Ramp duration: ceil(|Δcode| / STEP_LSB) × STEP_CYCLES cycles.
- `vout_ok` rises SETTLE_CYCLES cycles after the final step.

Fault timing:
- `fault` rising at edge N → FAULT after edge N; `vref_code` = 500 after edge N.
- `fault` falling → SETTLE on the next edge.

All outputs are registered.

## Structure

- Package `fcp_pkg`:
  - `out_volt` encodings: `FCP_V5`, `FCP_V9`, `FCP_V12`, `FCP_VRSV`.
  - Code constants `CODE_5V` = 500, `CODE_9V` = 900, `CODE_12V` = 1200.
  - State encoding typedef `ramp_state_t`.
- One sub-module, `fcp_tick_cnt`: a loadable down-counter with `load`, `load_val`, and a `zero` flag. It is instantiated twice, as the step timer and the settle timer.

## Test plan

All tests use STEP_CYCLES = 4, STEP_LSB = 10, SETTLE_CYCLES = 8.
- Reset release, `out_volt` = 00 → `vref_code` = 500 throughout; `vout_ok` rises exactly 8 cycles after reset deasserts.
- 00 → 01 from IDLE → `ramp_busy` high 2 cycles after the change; 40 steps of +10 every 4 cycles; `vref_code` = 900 after 160 cycles; `vout_ok` high 8 cycles later; `dischg_en` = 0 throughout.
- 10 (at 1200) → 00 → RAMP_DN with `dischg_en` = 1 for 70 steps (280 cycles); code ends exactly at 500; then SETTLE, then `vout_ok`.
- Ramp 5 → 12 V, switch to 01 when code = 1000 → direction reverses with no jump; descends to 900 and stops; no overshoot below 900.
- `fault` pulse at code 1050 mid-ramp → next cycle `vref_code` = 500, `dischg_en` = 1, `vout_ok` = 0. On release with `out_volt` = 10: SETTLE, then ramp restarts from 500 to 1200.
- `out_volt` = 11 from 9 V → ramp down to 500, same as 00.

Source files
------------

// File: rtl/fcp_pkg.sv
// Shared definitions for the FCP output-voltage ramp controller.
//   - out_volt request encodings from the FCP core
//   - DAC reference codes for each output voltage (10 mV/LSB)
//   - ramp controller state encoding
//   - volt_code(): request -> DAC code decode (reserved request maps to 5 V)
package fcp_pkg;

    localparam logic [1:0] FCP_V5   = 2'b00;
    localparam logic [1:0] FCP_V9   = 2'b01;
    localparam logic [1:0] FCP_V12  = 2'b10;
    localparam logic [1:0] FCP_VRSV = 2'b11;

    localparam int CODE_5V  = 500;
    localparam int CODE_9V  = 900;
    localparam int CODE_12V = 1200;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_FAULT   = 3'd4
    } ramp_state_t;

    function automatic int volt_code(input logic [1:0] v);
        case (v)
            FCP_V9:  return CODE_9V;
            FCP_V12: return CODE_12V;
            default: return CODE_5V;   // FCP_V5 and reserved
        endcase
    endfunction

endpackage

// File: rtl/fcp_tick_cnt.sv
// Loadable down-counter used as the ramp step timer and the settle timer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (counter -> RST_VAL)
//   load      - load load_val this edge (wins over counting)
//   load_val  - reload value
//   zero      - counter currently at zero; counter holds at zero
module fcp_tick_cnt #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= W'(RST_VAL);
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fcp_vout_ramp.sv
// Output-voltage ramp controller. Turns the FCP core's out_volt request into
// a slew-limited DAC reference code, bleeds VBUS on down-ramps, falls back to
// 5 V on fault and reports power-good once the output has settled.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   out_volt   - 00=5V 01=9V 10=12V 11=reserved (5V)
//   fault      - OVP/OCP level from the analog front end
//   vref_code  - DAC reference code (10 mV/LSB)
//   ramp_busy  - ramp in progress
//   dischg_en  - VBUS bleeder enable
//   vout_ok    - power good
module fcp_vout_ramp
    import fcp_pkg::*;
#(
    parameter int CODE_W        = 11,
    parameter int STEP_LSB      = 1,
    parameter int STEP_CYCLES   = 100,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        out_volt,
    input  logic              fault,
    output logic [CODE_W-1:0] vref_code,
    output logic              ramp_busy,
    output logic              dischg_en,
    output logic              vout_ok
);

    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SET_W-1:0]  SET_RELOAD  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W:0]   STEP_MAX    = (CODE_W+1)'(STEP_LSB);
    localparam logic [CODE_W-1:0] CODE_FB     = CODE_W'(CODE_5V);

    ramp_state_t       state, state_nxt;
    logic [CODE_W-1:0] tgt, code_nxt;
    logic              step_load, settle_load, step_zero, settle_zero;

    // Differences carried at CODE_W+1 bits so they can never wrap.
    logic [CODE_W:0] diff_up, diff_dn, inc, dec;
    logic            gt, lt;

    assign gt      = (tgt > vref_code);
    assign lt      = (tgt < vref_code);
    assign diff_up = {1'b0, tgt} - {1'b0, vref_code};
    assign diff_dn = {1'b0, vref_code} - {1'b0, tgt};
    assign inc     = (diff_up > STEP_MAX) ? STEP_MAX : diff_up;
    assign dec     = (diff_dn > STEP_MAX) ? STEP_MAX : diff_dn;

    fcp_tick_cnt #(.W(STEP_W), .RST_VAL(STEP_CYCLES - 1)) u_step_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (step_load),
        .load_val (STEP_RELOAD),
        .zero     (step_zero)
    );

    fcp_tick_cnt #(.W(SET_W), .RST_VAL(SETTLE_CYCLES - 1)) u_settle_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SET_RELOAD),
        .zero     (settle_zero)
    );

    // Next-state / next-code decode; also drives the timer reloads so the
    // counters stay in lock-step with state entry.
    always_comb begin
        state_nxt   = state;
        code_nxt    = vref_code;
        step_load   = 1'b0;
        settle_load = 1'b0;
        if (fault) begin
            state_nxt = ST_FAULT;
            code_nxt  = CODE_FB;
        end else begin
            case (state)
                ST_SETTLE, ST_IDLE: begin
                    if (gt) begin
                        state_nxt = ST_RAMP_UP;
                        step_load = 1'b1;
                    end else if (lt) begin
                        state_nxt = ST_RAMP_DN;
                        step_load = 1'b1;
                    end else if (state == ST_SETTLE && settle_zero) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RAMP_UP: begin
                    if (lt) begin
                        // target reversed: turn around from the current code
                        state_nxt = ST_RAMP_DN;
                        step_load = 1'b1;
                    end else if (!gt) begin
                        state_nxt   = ST_SETTLE;
                        settle_load = 1'b1;
                    end else if (step_zero) begin
                        code_nxt  = vref_code + inc[CODE_W-1:0];
                        step_load = 1'b1;
                        if (inc == diff_up) begin
                            state_nxt   = ST_SETTLE;
                            settle_load = 1'b1;
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (gt) begin
                        state_nxt = ST_RAMP_UP;
                        step_load = 1'b1;
                    end else if (!lt) begin
                        state_nxt   = ST_SETTLE;
                        settle_load = 1'b1;
                    end else if (step_zero) begin
                        code_nxt  = vref_code - dec[CODE_W-1:0];
                        step_load = 1'b1;
                        if (dec == diff_dn) begin
                            state_nxt   = ST_SETTLE;
                            settle_load = 1'b1;
                        end
                    end
                end
                default: begin   // ST_FAULT, fault released
                    state_nxt   = ST_SETTLE;
                    settle_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SETTLE;
            tgt       <= CODE_FB;
            vref_code <= CODE_FB;
            ramp_busy <= 1'b0;
            dischg_en <= 1'b0;
            vout_ok   <= 1'b0;
        end else begin
            tgt       <= fault ? CODE_FB : CODE_W'(volt_code(out_volt));
            state     <= state_nxt;
            vref_code <= code_nxt;
            ramp_busy <= (state_nxt == ST_RAMP_UP) || (state_nxt == ST_RAMP_DN);
            dischg_en <= (state_nxt == ST_RAMP_DN) || (state_nxt == ST_FAULT);
            vout_ok   <= (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fcp_vout_ramp.sv
module tb_fcp_vout_ramp;

    localparam int CODE_W = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        out_volt = 2'b00;
    logic              fault = 1'b0;
    logic [CODE_W-1:0] vref_code;
    logic              ramp_busy, dischg_en, vout_ok;

    int n_cmp = 0;
    int n_bad = 0;

    fcp_vout_ramp #(
        .CODE_W(CODE_W), .STEP_LSB(10), .STEP_CYCLES(4), .SETTLE_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_volt  (out_volt),
        .fault     (fault),
        .vref_code (vref_code),
        .ramp_busy (ramp_busy),
        .dischg_en (dischg_en),
        .vout_ok   (vout_ok)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, let the ramp finish, confirm the final code.
    task automatic go_to(input logic [1:0] ov, input int code);
        int waited;
        out_volt = ov;
        tick();
        tick();
        waited = 0;
        while (vout_ok !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (vout_ok !== 1'b1 || vref_code !== CODE_W'(code)) begin
            n_bad++;
            $display("FAIL go_to: vout_ok=%b code=%0d, required vout_ok=1 code=%0d", vout_ok, vref_code, code);
        end
    endtask

    // Wait for the ramp to reach a given code (bounded).
    task automatic wait_code(input int code);
        int waited;
        waited = 0;
        while (vref_code !== CODE_W'(code) && waited < 1000) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (vref_code !== CODE_W'(code)) begin
            n_bad++;
            $display("FAIL wait_code: code=%0d, required %0d", vref_code, code);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_f;
        rst = 1'b1;
        out_volt = 2'b00;
        fault = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (vref_code !== 11'd500 || {ramp_busy, dischg_en, vout_ok} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_vals: code=%0d busy/dis/ok=%b%b%b, required 500 000", vref_code, ramp_busy, dischg_en, vout_ok);
        end
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp_f = {1'b0, 1'b0, 1'b0, (t == 8)};
            n_cmp++;
            if (vref_code !== 11'd500 || {1'b0, ramp_busy, dischg_en, vout_ok} !== exp_f) begin
                n_bad++;
                $display("FAIL reset_release t=%0d: code=%0d busy/dis/ok=%b%b%b, required 500 ok=%b", t, vref_code, ramp_busy, dischg_en, vout_ok, exp_f[0]);
            end
        end
    endtask

    // 5 V -> 9 V from IDLE: 40 steps of +10 every 4 cycles.
    task automatic test_ramp_up();
        int n, exp_code;
        logic exp_busy, exp_ok;
        out_volt = 2'b01;
        for (int t = 1; t <= 170; t++) begin
            tick();
            n = (t < 6) ? 0 : (t - 6) / 4 + 1;
            if (n > 40) n = 40;
            exp_code = 500 + 10 * n;
            exp_busy = (t >= 2 && t <= 161);
            exp_ok   = (t < 2 || t == 170);
            n_cmp++;
            if (vref_code !== CODE_W'(exp_code) || {ramp_busy, dischg_en, vout_ok} !== {exp_busy, 1'b0, exp_ok}) begin
                n_bad++;
                $display("FAIL ramp_up t=%0d: code=%0d busy/dis/ok=%b%b%b, required %0d %b0%b", t, vref_code, ramp_busy, dischg_en, vout_ok, exp_code, exp_busy, exp_ok);
            end
        end
    endtask

    // Down-ramp from IDLE at 'start' by 'steps' steps of -10.
    task automatic test_ramp_dn(input int start, input logic [1:0] ov, input int steps);
        int n, exp_code, last;
        logic exp_busy, exp_ok;
        out_volt = ov;
        last = 2 + 4 * steps + 8;
        for (int t = 1; t <= last; t++) begin
            tick();
            n = (t < 6) ? 0 : (t - 6) / 4 + 1;
            if (n > steps) n = steps;
            exp_code = start - 10 * n;
            exp_busy = (t >= 2 && t <= 1 + 4 * steps);
            exp_ok   = (t < 2 || t == last);
            n_cmp++;
            if (vref_code !== CODE_W'(exp_code) || {ramp_busy, dischg_en, vout_ok} !== {exp_busy, exp_busy, exp_ok}) begin
                n_bad++;
                $display("FAIL ramp_dn ov=%b t=%0d: code=%0d busy/dis/ok=%b%b%b, required %0d %b%b%b", ov, t, vref_code, ramp_busy, dischg_en, vout_ok, exp_code, exp_busy, exp_busy, exp_ok);
            end
        end
    endtask

    // 5 V -> 12 V, retarget to 9 V at code 1000: turn around, stop at 900.
    task automatic test_reverse();
        int n, exp_code;
        logic exp_busy, exp_dis, exp_ok;
        out_volt = 2'b10;
        wait_code(1000);
        out_volt = 2'b01;
        for (int t = 1; t <= 50; t++) begin
            tick();
            n = (t < 6) ? 0 : (t - 6) / 4 + 1;
            if (n > 10) n = 10;
            exp_code = 1000 - 10 * n;
            exp_busy = (t <= 41);
            exp_dis  = (t >= 2 && t <= 41);
            exp_ok   = (t == 50);
            n_cmp++;
            if (vref_code !== CODE_W'(exp_code) || {ramp_busy, dischg_en, vout_ok} !== {exp_busy, exp_dis, exp_ok}) begin
                n_bad++;
                $display("FAIL reverse t=%0d: code=%0d busy/dis/ok=%b%b%b, required %0d %b%b%b", t, vref_code, ramp_busy, dischg_en, vout_ok, exp_code, exp_busy, exp_dis, exp_ok);
            end
        end
    endtask

    // Fault at code 1050 during 9 V -> 12 V, release with 12 V requested.
    task automatic test_fault();
        out_volt = 2'b10;
        wait_code(1050);
        fault = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            tick();
            n_cmp++;
            if (vref_code !== 11'd500 || {ramp_busy, dischg_en, vout_ok} !== 3'b010) begin
                n_bad++;
                $display("FAIL fault_hold t=%0d: code=%0d busy/dis/ok=%b%b%b, required 500 010", t, vref_code, ramp_busy, dischg_en, vout_ok);
            end
        end
        fault = 1'b0;
        tick();
        n_cmp++;
        if (vref_code !== 11'd500 || {ramp_busy, dischg_en, vout_ok} !== 3'b000) begin
            n_bad++;
            $display("FAIL fault_release: code=%0d busy/dis/ok=%b%b%b, required 500 000", vref_code, ramp_busy, dischg_en, vout_ok);
        end
        tick();
        n_cmp++;
        if (vref_code !== 11'd500 || {ramp_busy, dischg_en, vout_ok} !== 3'b100) begin
            n_bad++;
            $display("FAIL fault_restart: code=%0d busy/dis/ok=%b%b%b, required 500 100", vref_code, ramp_busy, dischg_en, vout_ok);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (vref_code !== 11'd500) begin
            n_bad++;
            $display("FAIL fault_pre_step: code=%0d, required 500", vref_code);
        end
        tick();
        n_cmp++;
        if (vref_code !== 11'd510 || ramp_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_first_step: code=%0d busy=%b, required 510 1", vref_code, ramp_busy);
        end
        go_to(2'b10, 1200);
    endtask

    // Reset asserted mid-ramp returns everything to reset values.
    task automatic test_reset_mid();
        out_volt = 2'b10;
        for (int t = 1; t <= 10; t++) tick();
        n_cmp++;
        if (vref_code !== 11'd520 || ramp_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_ramp: code=%0d busy=%b, required 520 1", vref_code, ramp_busy);
        end
        rst = 1'b1;
        out_volt = 2'b00;
        tick();
        n_cmp++;
        if (vref_code !== 11'd500 || {ramp_busy, dischg_en, vout_ok} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset: code=%0d busy/dis/ok=%b%b%b, required 500 000", vref_code, ramp_busy, dischg_en, vout_ok);
        end
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp++;
            if (vref_code !== 11'd500 || ramp_busy !== 1'b0 || vout_ok !== (t == 8)) begin
                n_bad++;
                $display("FAIL mid_reset_release t=%0d: code=%0d busy=%b ok=%b, required 500 0 %b", t, vref_code, ramp_busy, vout_ok, (t == 8));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        go_to(2'b10, 1200);
        test_ramp_dn(1200, 2'b00, 70);
        test_reverse();
        test_fault();
        go_to(2'b01, 900);
        test_ramp_dn(900, 2'b11, 40);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
